// File: rtl/instr_encoder_loader_if.sv
// Command / instruction-memory bus for instr_encoder_loader.
//   cmd_*  : decoded instruction command, valid/ready handshake
//   mem_*  : word write port toward instruction memory, mem_ready acks a write
// Modports:
//   slave  - encoder side (consumes commands, drives memory writes)
//   master - producer side (drives commands, models memory)
interface instr_encoder_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_kind;
  logic [4:0]            cmd_rs;
  logic [4:0]            cmd_rt;
  logic [4:0]            cmd_rd;
  logic [4:0]            cmd_shamt;
  logic [5:0]            cmd_funct;
  logic [15:0]           cmd_imm;
  logic                  cmd_last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;

  modport slave (
    input  cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_shamt,
           cmd_funct, cmd_imm, cmd_last, mem_ready,
    output cmd_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_shamt,
           cmd_funct, cmd_imm, cmd_last, mem_ready,
    input  cmd_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded instruction commands (R-type, ADDI,
// ORI, ANDI, LUI, BEQ, BNE) into 32-bit MIPS words and writes them to
// consecutive instruction-memory word addresses. Inverse of the opcode
// control decoder; used to load programs from the bench / boot path.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   restart    - pulse in DONE starts a new load session
//   bus        - instr_encoder_loader_if.slave (command handshake + memory write)
//   word_count - words written this session
//   done       - session finished (cmd_last written, overflow, or invalid last)
//   err        - sticky, an invalid cmd_kind was accepted
//   overflow   - sticky, MAX_WORDS reached before cmd_last
//   checksum   - running XOR of accepted words (only with WORD_CHECKSUM_EN)
//
// Optional feature macro: WORD_CHECKSUM_EN adds the checksum output.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  done,
  output logic                  err,
  output logic                  overflow
`ifdef WORD_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   MAX_W = AW1'(MAX_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] K_RTYPE = 3'd0;
  localparam logic [2:0] K_ADDI  = 3'd1;
  localparam logic [2:0] K_ORI   = 3'd2;
  localparam logic [2:0] K_ANDI  = 3'd3;
  localparam logic [2:0] K_LUI   = 3'd4;
  localparam logic [2:0] K_BEQ   = 3'd5;
  localparam logic [2:0] K_BNE   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        last;
  } cmd_t;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  last_q;
  logic [ADDR_WIDTH:0]   wc_inc;
  cmd_t                  cmd;
  logic [31:0]           enc_word;
  logic                  enc_ok;
  logic                  hs;
  logic                  wr_ack;
`ifdef WORD_CHECKSUM_EN
  logic [31:0]           cks_q;
`endif

  assign cmd = '{kind:  bus.cmd_kind,  rs:    bus.cmd_rs,
                 rt:    bus.cmd_rt,    rd:    bus.cmd_rd,
                 shamt: bus.cmd_shamt, funct: bus.cmd_funct,
                 imm:   bus.cmd_imm,   last:  bus.cmd_last};

  // Handshake/ready/strobe are pure decodes of the state register.
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.mem_we    = (state == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign done          = (state == S_DONE);
  assign hs            = bus.cmd_valid & bus.cmd_ready;
  assign wr_ack        = bus.mem_we & bus.mem_ready;
  assign wc_inc        = word_count + 1'b1;
`ifdef WORD_CHECKSUM_EN
  assign checksum      = cks_q;
`endif

  // Encoder: fields outside the command's class are simply not routed.
  always_comb begin
    enc_ok   = 1'b1;
    enc_word = '0;
    case (cmd.kind)
      K_RTYPE: enc_word = {OP_RTYPE, cmd.rs, cmd.rt, cmd.rd, cmd.shamt, cmd.funct};
      K_ADDI:  enc_word = {OP_ADDI, cmd.rs, cmd.rt, cmd.imm};
      K_ORI:   enc_word = {OP_ORI,  cmd.rs, cmd.rt, cmd.imm};
      K_ANDI:  enc_word = {OP_ANDI, cmd.rs, cmd.rt, cmd.imm};
      K_LUI:   enc_word = {OP_LUI,  5'd0,   cmd.rt, cmd.imm}; // LUI has no rs source
      K_BEQ:   enc_word = {OP_BEQ,  cmd.rs, cmd.rt, cmd.imm};
      K_BNE:   enc_word = {OP_BNE,  cmd.rs, cmd.rt, cmd.imm};
      default: enc_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_q     <= BASE;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      word_count <= '0;
      err        <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            if (enc_ok) begin
              wdata_q <= enc_word;
              last_q  <= cmd.last;
              state   <= S_WRITE;
            end else begin
              // Invalid command is dropped; only its last flag still counts.
              err <= 1'b1;
              if (cmd.last) state <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) begin
            addr_q     <= addr_q + 1'b1;  // wraps at 2^ADDR_WIDTH
            word_count <= wc_inc;
            if (last_q) begin
              state <= S_DONE;
            end else if (wc_inc == MAX_W) begin
              overflow <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (restart) begin
            addr_q     <= BASE;
            word_count <= '0;
            err        <= 1'b0;
            overflow   <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WORD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cks_q <= '0;
    end else if (done && restart) begin
      cks_q <= '0;
    end else if (wr_ack) begin
      cks_q <= cks_q ^ wdata_q;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic       restart;
  logic [8:0] word_count;
  logic       done, err, overflow;
`ifdef WORD_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_WIDTH(8)) bus ();

  instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0), .MAX_WORDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .bus        (bus),
    .word_count (word_count),
    .done       (done),
    .err        (err),
    .overflow   (overflow)
`ifdef WORD_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for cmd_ready at a falling edge, then offers one command
  // for exactly one rising edge. Returns at the next falling edge.
  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic last);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      bus.cmd_kind  = k;  bus.cmd_rs = rs; bus.cmd_rt = rt; bus.cmd_rd = rd;
      bus.cmd_shamt = sh; bus.cmd_funct = fn; bus.cmd_imm = imm; bus.cmd_last = last;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_kind = 3'd0; bus.cmd_rs = 5'd0; bus.cmd_rt = 5'd0;
    bus.cmd_rd = 5'd0; bus.cmd_shamt = 5'd0; bus.cmd_funct = 6'd0; bus.cmd_imm = 16'd0;
    bus.cmd_last = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    chk("rst_we",    32'(bus.mem_we), 0);
    chk("rst_addr",  32'(bus.mem_addr), 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_wc",    32'(word_count), 0);
    chk("rst_flags", {29'd0, done, err, overflow}, 0);
`ifdef WORD_CHECKSUM_EN
    chk("rst_cks", checksum, 0);
`endif

    // ADDI, irrelevant rd/shamt/funct deliberately nonzero
    send(3'd1, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3f, 16'h0005, 1'b0);
    chk("addi_we",   32'(bus.mem_we), 1);
    chk("addi_addr", 32'(bus.mem_addr), 0);
    chk("addi_data", bus.mem_wdata, 32'h20220005);
    @(negedge clk);
    chk("addi_wc",    32'(word_count), 1);
    chk("addi_addr1", 32'(bus.mem_addr), 1);
    chk("addi_idle",  {30'd0, bus.cmd_ready, bus.mem_we}, 32'b10);
    // restart outside DONE has no effect
    do_restart();
    chk("rs_ign_wc",   32'(word_count), 1);
    chk("rs_ign_addr", 32'(bus.mem_addr), 1);

    // R-type then LUI (rs forced to zero)
    do_reset();
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD, 1'b0);
    chk("rt_addr", 32'(bus.mem_addr), 0);
    chk("rt_data", bus.mem_wdata, 32'h00221820);
    send(3'd4, 5'd7, 5'd4, 5'd9, 5'd9, 6'h11, 16'h1234, 1'b1);
    chk("lui_addr", 32'(bus.mem_addr), 1);
    chk("lui_data", bus.mem_wdata, 32'h3C041234);
    @(negedge clk);
    chk("lui_done", 32'(done), 1);
    chk("lui_wc",   32'(word_count), 2);

    // BNE with last, memory stalls 3 cycles
    do_reset();
    bus.mem_ready = 1'b0;
    send(3'd6, 5'd1, 5'd0, 5'd0, 5'd0, 6'h00, 16'hFFFE, 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      chk("bne_we",   32'(bus.mem_we), 1);
      chk("bne_data", bus.mem_wdata, 32'h1420FFFE);
      chk("bne_addr", 32'(bus.mem_addr), 0);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("bne_done",  32'(done), 1);
    chk("bne_wc",    32'(word_count), 1);
    chk("bne_ready", 32'(bus.cmd_ready), 0);
    chk("bne_we0",   32'(bus.mem_we), 0);
`ifdef WORD_CHECKSUM_EN
    chk("bne_cks", checksum, 32'h1420FFFE);
`endif

    // invalid kind, then ORI at the same address
    do_restart();
    send(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001, 1'b0);
    chk("inv_err",   32'(err), 1);
    chk("inv_we",    32'(bus.mem_we), 0);
    chk("inv_addr",  32'(bus.mem_addr), 0);
    chk("inv_ready", 32'(bus.cmd_ready), 1);
    send(3'd2, 5'd3, 5'd5, 5'd0, 5'd0, 6'h00, 16'h00FF, 1'b1);
    chk("ori_addr", 32'(bus.mem_addr), 0);
    chk("ori_data", bus.mem_wdata, 32'h346500FF);
    @(negedge clk);
    chk("ori_done", {30'd0, done, err}, 32'b11);
    chk("ori_wc",   32'(word_count), 1);
    do_restart();
    chk("rst2_err",  32'(err), 0);
    chk("rst2_done", 32'(done), 0);
    chk("rst2_addr", 32'(bus.mem_addr), 0);
    chk("rst2_wc",   32'(word_count), 0);
`ifdef WORD_CHECKSUM_EN
    chk("rst2_cks", checksum, 0);
`endif

    // overflow at MAX_WORDS=4, combined with an invalid kind
    send(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      send(3'd1, 5'd0, 5'(i), 5'd0, 5'd0, 6'h00, 16'(i), 1'b0);
      chk("ovf_addr", 32'(bus.mem_addr), 32'(i - 1));
      chk("ovf_data", bus.mem_wdata, 32'h20000000 | (i << 16) | i);
    end
    @(negedge clk);
    chk("ovf_flags", {29'd0, done, err, overflow}, 32'b111);
    chk("ovf_wc",    32'(word_count), 4);
    chk("ovf_addr4", 32'(bus.mem_addr), 4);
`ifdef WORD_CHECKSUM_EN
    chk("ovf_cks", checksum, 32'h00040004);
`endif
    bus.cmd_kind = 3'd1; bus.cmd_last = 1'b0; bus.cmd_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("ovf5_we",    32'(bus.mem_we), 0);
      chk("ovf5_ready", 32'(bus.cmd_ready), 0);
      chk("ovf5_wc",    32'(word_count), 4);
    end
    bus.cmd_valid = 1'b0;

    // reset in the middle of a stalled write
    do_reset();
    send(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 1'b0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    send(3'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0F0F, 1'b0);
    chk("wr_rst_pre_we",   32'(bus.mem_we), 1);
    chk("wr_rst_pre_addr", 32'(bus.mem_addr), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("wr_rst_we",    32'(bus.mem_we), 0);
    chk("wr_rst_addr",  32'(bus.mem_addr), 0);
    chk("wr_rst_wdata", bus.mem_wdata, 0);
    chk("wr_rst_wc",    32'(word_count), 0);
    chk("wr_rst_ready", 32'(bus.cmd_ready), 1);
    chk("wr_rst_flags", {29'd0, done, err, overflow}, 0);
`ifdef WORD_CHECKSUM_EN
    chk("wr_rst_cks", checksum, 0);
`endif
    bus.mem_ready = 1'b1;
    send(3'd3, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'h00F0, 1'b0);
    chk("post_rst_addr", 32'(bus.mem_addr), 0);
    chk("post_rst_data", bus.mem_wdata, 32'h304300F0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Sequential instruction encoder that is the inverse of the opcode control decoder.
- Accepts decoded instruction commands (class plus fields) over a valid/ready handshake.
- Packs each command into a 32-bit MIPS word and writes it to consecutive instruction-memory addresses.
- Used by the bench and boot path to load programs using the supported subset: R-type, ADDI, ORI, ANDI, LUI, BEQ, BNE.

Parameters:
- ADDR_WIDTH, 8, width of the word address to instruction memory.
- BASE_ADDR, 0, first word address written after reset or restart.
- MAX_WORDS, 256, maximum number of words written per load session (must be ≤ 2^ADDR_WIDTH).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- restart  input  1  one-cycle pulse; starts a new session from DONE.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  encoder can accept a command.
- cmd_kind  input  3  0=R_TYPE, 1=ADDI, 2=ORI, 3=ANDI, 4=LUI, 5=BEQ, 6=BNE, 7=invalid.
- cmd_rs  input  5  rs field.
- cmd_rt  input  5  rt field.
- cmd_rd  input  5  rd field (R-type only).
- cmd_shamt  input  5  shamt field (R-type only).
- cmd_funct  input  6  funct field (R-type only).
- cmd_imm  input  16  immediate or branch offset (I-type only).
- cmd_last  input  1  this command ends the program.
- mem_we  output  1  write strobe to instruction memory.
- mem_addr  output  ADDR_WIDTH  word address.
- mem_wdata  output  32  encoded instruction.
- mem_ready  input  1  memory accepts the write this cycle.
- word_count  output  ADDR_WIDTH+1  words written this session.
- done  output  1  session finished.
- err  output  1  sticky: an invalid cmd_kind was seen.
- overflow  output  1  sticky: MAX_WORDS was reached before cmd_last.

Behaviour:
- Reset values: state=IDLE, cmd_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, done=0, err=0, overflow=0.
- Reset has priority over every other input and takes effect in any state. Reset during WRITE drops mem_we at that edge and the write is lost.
- Opcodes used for encoding: R_TYPE=6'h00, ADDI=6'h08, ORI=6'h0d, ANDI=6'h0c, LUI=6'h0f, BEQ=6'h04, BNE=6'h05.
- R-type word: {6'h00, rs, rt, rd, shamt, funct}.
- I-type word: {op, rs, rt, imm}.
- LUI forces the rs field to 0 regardless of cmd_rs.
- Fields that do not apply to a command's class are ignored.
- States: IDLE, WRITE, DONE.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) with a valid kind registers mem_wdata and latches cmd_last; next state is WRITE.
  - A handshake with kind=7 sets err, writes nothing, leaves mem_addr unchanged, and stays in IDLE. If cmd_last is also set, next state is DONE.
- WRITE:
  - cmd_ready=0, mem_we=1.
  - mem_addr and mem_wdata hold stable until mem_ready=1 is sampled.
  - On the edge where mem_ready=1:
    - mem_addr increments, wrapping modulo 2^ADDR_WIDTH.
    - word_count increments.
    - If the latched last flag is set, next state is DONE.
    - Otherwise, if word_count reaches MAX_WORDS, set overflow and go to DONE.
    - Otherwise return to IDLE.
- DONE:
  - done=1, cmd_ready=0, mem_we=0.
  - restart=1 clears done, word_count, err and overflow, sets mem_addr=BASE_ADDR, and returns to IDLE.
  - restart is ignored outside DONE.
- Timing:
  - Latency: handshake at edge N gives mem_we=1 during cycle N+1.
  - Best-case throughput is one word per 2 cycles.
  - Combined error and overflow in one session: both sticky flags are reported.

Optional Feature:
- Macro: WORD_CHECKSUM_EN.
- When defined: adds output port checksum [31:0], the running XOR of every word accepted by memory (mem_we & mem_ready). It resets to 0 on reset and on restart, and holds its value in DONE.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- ADDI rs=1, rt=2, imm=16'h0005 → mem_we in the next cycle, mem_addr=0, mem_wdata=32'h20220005.
- R_TYPE rs=1, rt=2, rd=3, shamt=0, funct=6'h20, then LUI rs=7, rt=4, imm=16'h1234 → writes 32'h00221820 at addr 0 and 32'h3C041234 at addr 1 (rs forced to 0).
- BNE rs=1, rt=0, imm=16'hFFFE with cmd_last=1, and mem_ready held low 3 cycles → mem_we and data 32'h1420FFFE stable for 4 cycles; then done=1, word_count=1, cmd_ready=0.
- cmd_kind=7 → err=1, no mem_we, mem_addr unchanged; a following valid ORI is still written at the same address. restart in DONE → err=0, mem_addr=BASE_ADDR.
- MAX_WORDS=4: 5 commands without last → 4 writes, then overflow=1, done=1, 5th command never accepted. With WORD_CHECKSUM_EN: checksum equals the XOR of the 4 written words.
- Assert reset while in WRITE → mem_we=0 and all outputs at reset values after that edge; the next command is written at BASE_ADDR.
